// File: rtl/sb_pkg.sv
// Shared constants and the buffered-store record for the store buffer.
package sb_pkg;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int PTR_W    = 2;
  localparam int DEPTH    = 1 << PTR_W;
  localparam int BE_W     = DW / 8;
  localparam int WORD_LSB = 2;

  localparam logic [BE_W-1:0] BE_FULL   = {BE_W{1'b1}};
  localparam logic [AW-1:0]   WORD_MASK = {{(AW-WORD_LSB){1'b1}}, {WORD_LSB{1'b0}}};

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [BE_W-1:0] be;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over all buffered stores for load forwarding.
module sb_fwd_match
  import sb_pkg::*;
(
  input  sb_entry_t          entries [DEPTH],
  input  logic [DEPTH-1:0]   valid,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  logic [AW-1:0]      ld_addr,
  output logic               match,
  output logic [PTR_W-1:0]   index,
  output logic               be_full
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest slot to youngest (wr_ptr-1) so the last hit found is the youngest one.
  always_comb begin
    match   = 1'b0;
    index   = '0;
    be_full = 1'b0;
    idx     = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - PTR_W'(k);
      if (valid[idx] && ((entries[idx].addr & WORD_MASK) == (ld_addr & WORD_MASK))) begin
        match   = 1'b1;
        index   = idx;
        be_full = (entries[idx].be == BE_FULL);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of committed stores drained to dmem with load forwarding.
module store_buffer
  import sb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [AW-1:0]     enq_addr,
  input  logic [DW-1:0]     enq_data,
  input  logic [BE_W-1:0]   enq_be,
  output logic              dmem_req,
  output logic [AW-1:0]     dmem_addr,
  output logic [DW-1:0]     dmem_wdata,
  output logic [BE_W-1:0]   dmem_be,
  input  logic              dmem_ack,
  input  logic [AW-1:0]     ld_addr,
  output logic              ld_hit,
  output logic [DW-1:0]     ld_data,
  output logic              ld_conflict,
  output logic              sb_empty,
  output logic [PTR_W:0]    sb_count
);

  sb_entry_t          entries [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic [PTR_W-1:0]   wr_idx;
  logic [PTR_W-1:0]   rd_idx;
  logic               full;
  logic               empty;
  logic               enq_fire;
  logic               deq_fire;
  logic               fwd_match;
  logic [PTR_W-1:0]   fwd_index;
  logic               fwd_be_full;

  assign wr_idx = wr_ptr[PTR_W-1:0];
  assign rd_idx = rd_ptr[PTR_W-1:0];

  // The extra pointer MSB distinguishes full from empty when the slot indices coincide.
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
  assign empty = (wr_ptr == rd_ptr);

  // Full is judged before any same-cycle ack, so a draining ack never opens a slot early.
  assign enq_ready = !full;
  assign enq_fire  = enq_valid && !full;
  assign dmem_req  = !empty;
  assign deq_fire  = dmem_req && dmem_ack;

  assign dmem_addr  = entries[rd_idx].addr & WORD_MASK;
  assign dmem_wdata = entries[rd_idx].data;
  assign dmem_be    = entries[rd_idx].be;

  assign sb_empty = empty;
  assign sb_count = wr_ptr - rd_ptr;

  // Pointer and valid-bit bookkeeping; a reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= '0;
    end else begin
      if (enq_fire) begin
        valid[wr_idx] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (deq_fire) begin
        valid[rd_idx] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
    end
  end

  // Entry payload storage carries no reset; valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      entries[wr_idx] <= '{addr: enq_addr, data: enq_data, be: enq_be};
    end
  end

  sb_fwd_match u_fwd (
    .entries (entries),
    .valid   (valid),
    .wr_ptr  (wr_idx),
    .ld_addr (ld_addr),
    .match   (fwd_match),
    .index   (fwd_index),
    .be_full (fwd_be_full)
  );

  assign ld_hit      = fwd_match && fwd_be_full;
  assign ld_conflict = fwd_match && !fwd_be_full;
  assign ld_data     = ld_hit ? entries[fwd_index].data : '0;

endmodule
